// File: rtl/led_pattern_checker.sv
// led_pattern_checker: watches a one-hot rotating LED bus,
// locks onto a correct stream and latches the first deviation.
module led_pattern_checker #(
   parameter int WIDTH    = 2,
   parameter int PERIOD   = 4,
   parameter bit DIR      = 1'b0,
   parameter int LOCK_ROT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] led_in,
   input  logic             enable,
   input  logic             clear,
   output logic             locked,
   output logic             error,
   output logic [2:0]       err_code,
   output logic [15:0]      rot_count
);

   localparam int CW = $clog2(PERIOD + 1);
   localparam int GW = $clog2(LOCK_ROT + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(PERIOD - 1);
   localparam logic [CW-1:0] CYC_MAX  = CW'(PERIOD);
   localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_ROT - 1);

   typedef enum logic [1:0] {
      S_HUNT,
      S_SYNC,
      S_LOCKED,
      S_ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sample_q, sample_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [CW-1:0]    cyc_q, cyc_d;
   logic [GW-1:0]    good_q, good_d;
   logic [15:0]      rot_q, rot_d;
   logic [2:0]       code_q, code_d;

   logic [WIDTH-1:0] rot_prev;
   logic             chg;
   logic             onehot;
   logic             step_ok;
   logic [2:0]       ev_code;
   logic             ev_good;

   if (DIR == 1'b0) begin : g_right
      assign rot_prev = {prev_q[0], prev_q[WIDTH-1:1]};
   end else begin : g_left
      assign rot_prev = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
   end

   assign chg     = (sample_q != prev_q);
   assign onehot  = $onehot(sample_q);
   assign step_ok = (sample_q == rot_prev);

   // capture pipeline and interval counter since the last change
   always_comb begin
      sample_d = led_in;
      prev_d   = sample_q;
      cyc_d    = cyc_q;
      if (!enable || chg) begin
         cyc_d = '0;
      end else if (cyc_q != CYC_MAX) begin
         cyc_d = cyc_q + 1'b1;
      end
   end

   // classify the current sample, highest priority fault first
   always_comb begin
      ev_code = 3'd0;
      ev_good = 1'b0;
      if (!onehot) begin
         ev_code = 3'd1;
      end else if (chg && !step_ok) begin
         ev_code = 3'd2;
      end else if (chg && (cyc_q < CYC_LAST)) begin
         ev_code = 3'd3;
      end else if (!chg && (cyc_q == CYC_LAST)) begin
         ev_code = 3'd4;
      end else if (chg) begin
         ev_good = 1'b1;
      end
   end

   // lock/error state machine; clear overrides everything
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      rot_d   = rot_q;
      code_d  = code_q;
      if (clear) begin
         state_d = S_HUNT;
         good_d  = '0;
         rot_d   = '0;
         code_d  = 3'd0;
      end else if (state_q != S_ERROR) begin
         if (!enable) begin
            state_d = S_HUNT;
            good_d  = '0;
         end else begin
            case (state_q)
               S_HUNT: begin
                  if (chg && onehot && step_ok) begin
                     state_d = S_SYNC;
                     good_d  = '0;
                  end
               end
               S_SYNC: begin
                  if (ev_code != 3'd0) begin
                     state_d = S_HUNT;
                  end else if (ev_good) begin
                     good_d = good_q + 1'b1;
                     if (good_q == GOOD_LAST) begin
                        state_d = S_LOCKED;
                     end
                  end
               end
               S_LOCKED: begin
                  if (ev_code != 3'd0) begin
                     state_d = S_ERROR;
                     code_d  = ev_code;
                  end else if (ev_good && (rot_q != 16'hFFFF)) begin
                     rot_d = rot_q + 16'd1;
                  end
               end
               default: begin
                  state_d = state_q;
               end
            endcase
         end
      end
   end

   // state registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_HUNT;
         sample_q <= '0;
         prev_q   <= '0;
         cyc_q    <= '0;
         good_q   <= '0;
         rot_q    <= '0;
         code_q   <= 3'd0;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         prev_q   <= prev_d;
         cyc_q    <= cyc_d;
         good_q   <= good_d;
         rot_q    <= rot_d;
         code_q   <= code_d;
      end
   end

   assign locked    = (state_q == S_LOCKED);
   assign error     = (state_q == S_ERROR);
   assign err_code  = code_q;
   assign rot_count = rot_q;

endmodule

// File: tb/tb_led_pattern_checker.sv
// tb_led_pattern_checker: three checker instances driven by
// directed and random LED streams, compared to a stream model.
module tb_led_pattern_checker;

   localparam int N = 3;
   localparam int PER = 4;

   int W [N] = '{2, 4, 4};
   bit D [N] = '{1'b0, 1'b0, 1'b1};
   int L [N] = '{2, 2, 3};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic clear = 1'b0;
   logic [3:0] drv [N];
   logic [1:0] led0;
   logic [3:0] led1, led2;

   logic        lk [N];
   logic        er [N];
   logic [2:0]  ec [N];
   logic [15:0] rc [N];

   int errors = 0;
   int checks = 0;

   assign led0 = drv[0][1:0];
   assign led1 = drv[1];
   assign led2 = drv[2];

   always #5 clk = ~clk;

   led_pattern_checker u0 (
      .clk(clk), .rst(rst), .led_in(led0),
      .enable(enable), .clear(clear),
      .locked(lk[0]), .error(er[0]),
      .err_code(ec[0]), .rot_count(rc[0])
   );

   led_pattern_checker #(
      .WIDTH(4), .PERIOD(4), .DIR(1'b0), .LOCK_ROT(2)
   ) u1 (
      .clk(clk), .rst(rst), .led_in(led1),
      .enable(enable), .clear(clear),
      .locked(lk[1]), .error(er[1]),
      .err_code(ec[1]), .rot_count(rc[1])
   );

   led_pattern_checker #(
      .WIDTH(4), .PERIOD(4), .DIR(1'b1), .LOCK_ROT(3)
   ) u2 (
      .clk(clk), .rst(rst), .led_in(led2),
      .enable(enable), .clear(clear),
      .locked(lk[2]), .error(er[2]),
      .err_code(ec[2]), .rot_count(rc[2])
   );

   function automatic logic [3:0] rotf(
      input logic [3:0] v, input int w, input bit d);
      int x, m;
      x = int'(v);
      m = (1 << w) - 1;
      if (!d) x = (x >> 1) | ((x & 1) << (w - 1));
      else    x = (x << 1) | (x >> (w - 1));
      return 4'(x & m);
   endfunction

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0h expected %0h",
                  nm, k, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 hunting, 1 syncing, 2 locked, 3 error
   int         m_mode  [N];
   logic [3:0] m_s     [N];
   logic [3:0] m_p     [N];
   int         m_quiet [N];
   int         m_good  [N];
   int         m_rot   [N];
   int         m_code  [N];

   task automatic model_reset(input int k);
      m_mode[k]  = 0;
      m_s[k]     = '0;
      m_p[k]     = '0;
      m_quiet[k] = 0;
      m_good[k]  = 0;
      m_rot[k]   = 0;
      m_code[k]  = 0;
   endtask

   task automatic model_edge(input int k, input logic [3:0] led);
      bit chg, oh, sok;
      int cls;
      chg = (m_s[k] != m_p[k]);
      oh  = ($countones(m_s[k]) == 1);
      sok = (m_s[k] == rotf(m_p[k], W[k], D[k]));
      cls = 0;
      if (!oh)                                cls = 1;
      else if (chg && !sok)                   cls = 2;
      else if (chg && m_quiet[k] < PER - 1)   cls = 3;
      else if (!chg && m_quiet[k] == PER - 1) cls = 4;
      else if (chg)                           cls = 5;
      if (clear) begin
         m_mode[k] = 0;
         m_code[k] = 0;
         m_rot[k]  = 0;
      end else if (m_mode[k] != 3) begin
         if (!enable) begin
            m_mode[k] = 0;
         end else if (m_mode[k] == 0) begin
            if (chg && oh && sok) begin
               m_mode[k] = 1;
               m_good[k] = 0;
            end
         end else if (m_mode[k] == 1) begin
            if (cls >= 1 && cls <= 4) begin
               m_mode[k] = 0;
            end else if (cls == 5) begin
               m_good[k]++;
               if (m_good[k] == L[k]) m_mode[k] = 2;
            end
         end else begin
            if (cls >= 1 && cls <= 4) begin
               m_mode[k] = 3;
               m_code[k] = cls;
            end else if (cls == 5 && m_rot[k] < 65535) begin
               m_rot[k]++;
            end
         end
      end
      m_quiet[k] = chg ? 0 : m_quiet[k] + 1;
      m_p[k] = m_s[k];
      m_s[k] = led;
   endtask

   initial begin
      for (int k = 0; k < N; k++) model_reset(k);
   end

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < N; k++) begin
         if (rst) model_reset(k);
         else     model_edge(k, drv[k]);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         chk("locked", k, 32'(lk[k]), 32'(m_mode[k] == 2));
         chk("error", k, 32'(er[k]), 32'(m_mode[k] == 3));
         chk("err_code", k, 32'(ec[k]), 32'(m_code[k]));
         chk("rot_count", k, 32'(rc[k]), 32'(m_rot[k]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic rotate_all(input int n);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < N; k++) drv[k] = rotf(drv[k], W[k], D[k]);
         step(PER);
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   logic [3:0] saved [N];

   initial begin
      for (int k = 0; k < N; k++) drv[k] = 4'b0001;
      enable = 1'b1;
      step(3);
      chk("reset_locked", 0, 32'(lk[0]), 32'd0);
      chk("reset_rot", 0, 32'(rc[0]), 32'd0);
      rst = 1'b0;
      step(4);

      // lock onto a clean stream
      rotate_all(10);
      chk("lit_locked", 0, 32'(lk[0]), 32'd1);
      chk("lit_rot10", 0, 32'(rc[0]), 32'd7);
      chk("lit_rot10_l3", 2, 32'(rc[2]), 32'd6);

      // stall
      step(8);
      chk("lit_stall_err", 0, 32'(er[0]), 32'd1);
      chk("lit_stall_code", 0, 32'(ec[0]), 32'd4);
      chk("lit_stall_lock", 0, 32'(lk[0]), 32'd0);
      rotate_all(3);
      chk("lit_frozen_rot", 0, 32'(rc[0]), 32'd7);
      pulse_clear();
      chk("lit_clear_code", 0, 32'(ec[0]), 32'd0);
      chk("lit_clear_rot", 0, 32'(rc[0]), 32'd0);
      rotate_all(6);
      chk("lit_relock_rot", 0, 32'(rc[0]), 32'd3);

      // not one-hot glitch
      for (int k = 0; k < N; k++) saved[k] = drv[k];
      drv[0] = 4'b0011;
      drv[1] = 4'b0000;
      drv[2] = 4'b0110;
      step(1);
      for (int k = 0; k < N; k++) drv[k] = saved[k];
      step(1);
      chk("lit_onehot_code", 0, 32'(ec[0]), 32'd1);
      rotate_all(2);
      chk("lit_onehot_rot", 0, 32'(rc[0]), 32'd3);
      pulse_clear();
      rotate_all(6);

      // early change
      for (int k = 0; k < N; k++) drv[k] = rotf(drv[k], W[k], D[k]);
      step(2);
      rotate_all(1);
      chk("lit_early_code", 0, 32'(ec[0]), 32'd3);
      pulse_clear();
      rotate_all(6);

      // bad step (two positions); width 2 sees no change and stalls
      for (int k = 0; k < N; k++)
         drv[k] = rotf(rotf(drv[k], W[k], D[k]), W[k], D[k]);
      step(PER);
      chk("lit_step_code", 1, 32'(ec[1]), 32'd2);
      chk("lit_step_w2_code", 0, 32'(ec[0]), 32'd4);
      pulse_clear();
      rotate_all(6);

      // error and clear in the same cycle
      for (int k = 0; k < N; k++) saved[k] = drv[k];
      drv[0] = 4'b0011;
      drv[1] = 4'b0000;
      drv[2] = 4'b0110;
      step(1);
      clear = 1'b1;
      for (int k = 0; k < N; k++) drv[k] = saved[k];
      step(1);
      clear = 1'b0;
      chk("lit_clrwin_err", 0, 32'(er[0]), 32'd0);
      chk("lit_clrwin_lock", 0, 32'(lk[0]), 32'd0);
      rotate_all(6);

      // enable low while locked
      enable = 1'b0;
      step(3);
      chk("lit_en_lock", 0, 32'(lk[0]), 32'd0);
      rotate_all(2);
      chk("lit_en_rot", 0, 32'(rc[0]), 32'd3);
      enable = 1'b1;
      rotate_all(6);
      chk("lit_en_rot2", 0, 32'(rc[0]), 32'd6);

      // enable low while in error
      step(8);
      enable = 1'b0;
      step(2);
      chk("lit_en_err", 0, 32'(er[0]), 32'd1);
      enable = 1'b1;
      pulse_clear();

      // stall during sync
      rotate_all(1);
      step(8);
      chk("lit_sync_stall_err", 0, 32'(er[0]), 32'd0);
      chk("lit_sync_stall_lk", 0, 32'(lk[0]), 32'd0);

      // asynchronous reset while locked
      rotate_all(6);
      rst = 1'b1;
      #1;
      chk("lit_rst_lock", 0, 32'(lk[0]), 32'd0);
      chk("lit_rst_rot", 0, 32'(rc[0]), 32'd0);
      step(2);
      rst = 1'b0;
      rotate_all(5);

      // random stream with faults, clears and enable drops
      for (int i = 0; i < 400; i++) begin
         int h, r;
         for (int k = 0; k < N; k++) begin
            int m;
            logic [3:0] v;
            m = (1 << W[k]) - 1;
            r = $urandom_range(0, 99);
            if (r < 80) begin
               drv[k] = rotf(drv[k], W[k], D[k]);
            end else if (r < 88) begin
               v = 4'($urandom_range(0, m));
               if ($countones(v) == 1) v = 4'b0000;
               drv[k] = v;
            end else if (r < 95) begin
               drv[k] = 4'(1 << $urandom_range(0, W[k] - 1));
            end
         end
         r = $urandom_range(0, 99);
         clear  = (r < 5);
         enable = !(r >= 5 && r < 8);
         r = $urandom_range(0, 9);
         h = (r < 8) ? PER : $urandom_range(1, 7);
         step(1);
         clear  = 1'b0;
         enable = 1'b1;
         if (h > 1) step(h - 1);
      end

      step(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
